// File: rtl/digital_tube_driver.sv
// Bus-writable driver for a multiplexed common-anode 7-segment display; one digit lit per scan slot.
// Optional blink feature enabled by defining TUBE_BLINK_EN.
module digital_tube_driver #(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  addr_i,
  input  logic        we_i,
  input  logic [31:0] din_i,
  output logic [31:0] dout_o,
  output logic [7:0]  seg_n_o,
  output logic [7:0]  an_n_o
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [31:0]     data_q, data_d;
  logic            en_q, en_d;
  logic [7:0]      dp_q, dp_d;
  logic [7:0]      seg_n_q, seg_n_d;
  logic [7:0]      an_n_q, an_n_d;
  logic            cnt_wrap;
  logic            blink_off;
  logic            blink_rd;
  logic            wr_data, wr_ctrl;
  logic            unused_addr;

  assign unused_addr = ^{addr_i[7:4], addr_i[1:0]};
  assign wr_data     = we_i && (addr_i[3:2] == 2'd0);
  assign wr_ctrl     = we_i && (addr_i[3:2] == 2'd1);

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

`ifdef TUBE_BLINK_EN
  localparam int unsigned BlinkW = $clog2(BLINK_DIV);

  logic [BlinkW-1:0] bcnt_q, bcnt_d;
  logic              phase_q, phase_d;
  logic              blink_q, blink_d;

  always_comb begin
    bcnt_d  = bcnt_q + 1'b1;
    phase_d = phase_q;
    blink_d = blink_q;
    if (bcnt_q == BlinkW'(BLINK_DIV - 1)) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
    if (wr_ctrl) blink_d = din_i[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      blink_q <= blink_d;
    end
  end

  assign blink_off = blink_q & phase_q;
  assign blink_rd  = blink_q;
`else
  logic unused_blink_div;
  assign unused_blink_div = ^BLINK_DIV;
  assign blink_off        = 1'b0;
  assign blink_rd         = 1'b0;
`endif

  always_comb begin
    cnt_wrap = (cnt_q == CntW'(SCAN_DIV - 1));
    cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (cnt_wrap) idx_d = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;

    data_d = wr_data ? din_i : data_q;
    en_d   = wr_ctrl ? din_i[0] : en_q;
    dp_d   = wr_ctrl ? din_i[15:8] : dp_q;

    // Outputs are computed from pre-edge state, giving one cycle of latency.
    if (en_q && !blink_off) begin
      an_n_d  = ~(8'b1 << idx_q);
      seg_n_d = {~dp_q[idx_q], ~hex7(data_q[{idx_q, 2'b00} +: 4])};
    end else begin
      an_n_d  = 8'hFF;
      seg_n_d = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      dp_q    <= '0;
      seg_n_q <= 8'hFF;
      an_n_q  <= 8'hFF;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      en_q    <= en_d;
      dp_q    <= dp_d;
      seg_n_q <= seg_n_d;
      an_n_q  <= an_n_d;
    end
  end

  always_comb begin
    dout_o = '0;
    unique case (addr_i[3:2])
      2'd0:    dout_o = data_q;
      2'd1:    dout_o = {16'h0, dp_q, 6'h0, blink_rd, en_q};
      default: dout_o = '0;
    endcase
  end

  assign seg_n_o = seg_n_q;
  assign an_n_o  = an_n_q;

endmodule

// File: tb/tb_digital_tube_driver.sv
// Directed self-checking bench for digital_tube_driver (SCAN_DIV=4, DIGITS=8, BLINK_DIV=16).
module tb_digital_tube_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  addr_i;
  logic        we_i;
  logic [31:0] din_i;
  logic [31:0] dout_o;
  logic [7:0]  seg_n_o;
  logic [7:0]  an_n_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  digital_tube_driver #(
    .DIGITS   (8),
    .SCAN_DIV (4),
    .BLINK_DIV(16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .addr_i (addr_i),
    .we_i   (we_i),
    .din_i  (din_i),
    .dout_o (dout_o),
    .seg_n_o(seg_n_o),
    .an_n_o (an_n_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    addr_i = a;
    din_i  = d;
    we_i   = 1'b1;
    @(negedge clk);
    we_i   = 1'b0;
  endtask

  task automatic read_chk(input logic [7:0] a, input logic [31:0] exp, input string tag);
    addr_i = a;
    #1;
    check(tag, dout_o, exp);
  endtask

  task automatic wait_an(input logic [7:0] v, input string tag);
    int n = 0;
    while (an_n_o !== v && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, {24'h0, an_n_o}, {24'h0, v});
  endtask

  // Walk one full aligned scan frame starting at the first cycle of digit 0.
  task automatic scan_check(input logic [31:0] d, input logic [7:0] dp, input string tag);
    logic [7:0] exp_an;
    logic [7:0] exp_seg;
    wait_an(8'h7F, tag);
    wait_an(8'hFE, tag);
    for (int k = 0; k < 8; k++) begin
      exp_an  = ~(8'b1 << k);
      exp_seg = {~dp[k], ~hex_tab[d[4*k +: 4]]};
      for (int c = 0; c < 4; c++) begin
        check({tag, "_an"}, {24'h0, an_n_o}, {24'h0, exp_an});
        check({tag, "_seg"}, {24'h0, seg_n_o}, {24'h0, exp_seg});
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [7:0] prev;
    int n;
    reset  = 1'b1;
    we_i   = 1'b0;
    addr_i = 8'h00;
    din_i  = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset: dark display, all registers zero.
    repeat (40) @(negedge clk);
    check("t1_seg", {24'h0, seg_n_o}, 32'hFF);
    check("t1_an", {24'h0, an_n_o}, 32'hFF);
    read_chk(8'h00, 32'h0, "t1_rd0");
    read_chk(8'h04, 32'h0, "t1_rd4");
    read_chk(8'h08, 32'h0, "t1_rd8");
    read_chk(8'h0C, 32'h0, "t1_rdC");

    // Plain scan.
    @(negedge clk);
    bus_write(8'h00, 32'h0123ABCF);
    bus_write(8'h04, 32'h0000_0001);
    read_chk(8'h00, 32'h0123ABCF, "t2_rd0");
    scan_check(32'h0123ABCF, 8'h00, "t2");

    // Decimal points on digits 0 and 7.
    bus_write(8'h04, 32'h0000_8101);
    read_chk(8'h04, 32'h0000_8101, "t3_rd4");
    scan_check(32'h0123ABCF, 8'h81, "t3");

    // DATA write landing on the same edge as a scan wrap.
    prev = an_n_o;
    n = 0;
    while (an_n_o == prev && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t4_sync", {31'h0, an_n_o != prev}, 32'h1);
    prev = an_n_o;
    repeat (2) @(negedge clk);
    bus_write(8'h00, 32'h88888888);
    check("t4_old_an", {24'h0, an_n_o}, {24'h0, prev});
    @(negedge clk);
    check("t4_new_an", {24'h0, an_n_o}, {24'h0, prev[6:0], prev[7]});
    check("t4_new_seg", {25'h0, seg_n_o[6:0]}, 32'h0);
    bus_write(8'h08, 32'hDEADBEEF);
    read_chk(8'h08, 32'h0, "t4_rd8");
    read_chk(8'h0C, 32'h0, "t4_rdC");
    read_chk(8'h00, 32'h88888888, "t4_rd0");
    read_chk(8'h04, 32'h0000_8101, "t4_rd4");

    // Reset while digit 5 is lit.
    wait_an(8'hDF, "t5_idx5");
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_seg", {24'h0, seg_n_o}, 32'hFF);
    check("t5_rst_an", {24'h0, an_n_o}, 32'hFF);
    read_chk(8'h00, 32'h0, "t5_rd0");
    read_chk(8'h04, 32'h0, "t5_rd4");
    reset  = 1'b0;
    addr_i = 8'h04;
    din_i  = 32'h1;
    we_i   = 1'b1;
    @(negedge clk);
    we_i = 1'b0;
    @(negedge clk);
    check("t5_first_an", {24'h0, an_n_o}, 32'hFE);
    check("t5_first_seg", {24'h0, seg_n_o}, 32'hC0);
    repeat (3) @(negedge clk);
    check("t5_second_an", {24'h0, an_n_o}, 32'hFD);
    check("t5_second_seg", {24'h0, seg_n_o}, 32'hC0);

    // Blink control.
    bus_write(8'h04, 32'h0000_0003);
`ifdef TUBE_BLINK_EN
    read_chk(8'h04, 32'h3, "t6_rd4");
    n = 0;
    while (an_n_o != 8'hFF && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t6_off_sync", {24'h0, an_n_o}, 32'hFF);
    n = 0;
    while (an_n_o == 8'hFF && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 16; c++) begin
        check("t6_on", {31'h0, an_n_o != 8'hFF}, 32'h1);
        @(negedge clk);
      end
      for (int c = 0; c < 16; c++) begin
        check("t6_off_an", {24'h0, an_n_o}, 32'hFF);
        check("t6_off_seg", {24'h0, seg_n_o}, 32'hFF);
        @(negedge clk);
      end
    end
`else
    read_chk(8'h04, 32'h1, "t6_rd4");
    @(negedge clk);
    check("t6_no_blink_an", {31'h0, an_n_o != 8'hFF}, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
